instr_issue: RTL and testbench

//  Instruction fetch/issue sequencer: the producer side of the 2-bit opcode path consumed by the control decoder.

---
 rtl/instr_issue_if.sv | 27 ++
 rtl/instr_issue.sv | 127 ++++++++++++
 tb/tb_instr_issue.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_issue_if.sv
// Issue-sequencer bus bundle: instruction-memory read port, issue handshake and branch resolution.
interface instr_issue_if #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned INSTR_W = 8
);
    logic               ImemRd;
    logic [PC_W-1:0]    ImemAddr;
    logic [INSTR_W-1:0] ImemData;
    logic [1:0]         Op;
    logic [1:0]         Rs;
    logic [1:0]         Rt;
    logic [1:0]         Imm;
    logic               IssueValid;
    logic               IssueReady;
    logic               BrValid;
    logic               BrTaken;

    modport master (
        output ImemRd, ImemAddr, Op, Rs, Rt, Imm, IssueValid,
        input  ImemData, IssueReady, BrValid, BrTaken
    );

    modport slave (
        input  ImemRd, ImemAddr, Op, Rs, Rt, Imm, IssueValid,
        output ImemData, IssueReady, BrValid, BrTaken
    );
endinterface

// File: rtl/instr_issue.sv
// Instruction fetch/issue sequencer with branch stall; optional perf counters under INSTR_ISSUE_PERF_EN.
// Memory data arrives the cycle after ImemRd, so ISSUE captures it on its first cycle, then raises IssueValid.
module instr_issue #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned INSTR_W = 8
) (
    input  logic                Clk,
    input  logic                Clear_n,
    input  logic                Start,
    input  logic                Stop,
    output logic                Busy,
    instr_issue_if.master       bus
`ifdef INSTR_ISSUE_PERF_EN
    ,
    output logic [15:0]         IssueCount,
    output logic [15:0]         BrTakenCount
`endif
);
    localparam int unsigned OP_HI  = INSTR_W - 1;
    localparam int unsigned RS_HI  = INSTR_W - 3;
    localparam int unsigned RT_HI  = INSTR_W - 5;
    localparam int unsigned IMM_HI = INSTR_W - 7;
    localparam logic [1:0]  OP_BR  = 2'b11;

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, BR_WAIT} state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_inc_c;
    logic [PC_W-1:0] pc_nxt_c;
    logic            accept_c;

    assign accept_c = bus.IssueValid && bus.IssueReady;

    // Next PC at an instruction boundary: sequential, or branch target when taken in BR_WAIT.
    always_comb begin
        pc_inc_c = pc + PC_W'(1);
        pc_nxt_c = pc_inc_c;
        if (state == BR_WAIT && bus.BrTaken)
            pc_nxt_c = pc_inc_c + {{(PC_W-2){bus.Imm[1]}}, bus.Imm};
    end

    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            state          <= IDLE;
            pc             <= '0;
            bus.ImemRd     <= 1'b0;
            bus.ImemAddr   <= '0;
            bus.Op         <= 2'b00;
            bus.Rs         <= 2'b00;
            bus.Rt         <= 2'b00;
            bus.Imm        <= 2'b00;
            bus.IssueValid <= 1'b0;
            Busy           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        pc           <= '0;
                        bus.ImemAddr <= '0;
                        bus.ImemRd   <= 1'b1;
                        Busy         <= 1'b1;
                        state        <= FETCH;
                    end
                end
                FETCH: begin
                    bus.ImemRd <= 1'b0;
                    state      <= ISSUE;
                end
                ISSUE: begin
                    if (!bus.IssueValid) begin
                        bus.Op         <= bus.ImemData[OP_HI  -: 2];
                        bus.Rs         <= bus.ImemData[RS_HI  -: 2];
                        bus.Rt         <= bus.ImemData[RT_HI  -: 2];
                        bus.Imm        <= bus.ImemData[IMM_HI -: 2];
                        bus.IssueValid <= 1'b1;
                    end else if (accept_c) begin
                        bus.IssueValid <= 1'b0;
                        if (bus.Op == OP_BR) begin
                            state <= BR_WAIT;
                        end else begin
                            pc <= pc_nxt_c;
                            if (Stop) begin
                                Busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                bus.ImemAddr <= pc_nxt_c;
                                bus.ImemRd   <= 1'b1;
                                state        <= FETCH;
                            end
                        end
                    end
                end
                BR_WAIT: begin
                    if (bus.BrValid) begin
                        pc <= pc_nxt_c;
                        if (Stop) begin
                            Busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            bus.ImemAddr <= pc_nxt_c;
                            bus.ImemRd   <= 1'b1;
                            state        <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INSTR_ISSUE_PERF_EN
    // Saturating event counters.
    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            IssueCount   <= 16'd0;
            BrTakenCount <= 16'd0;
        end else begin
            if (accept_c && IssueCount != 16'hFFFF)
                IssueCount <= IssueCount + 16'd1;
            if (state == BR_WAIT && bus.BrValid && bus.BrTaken && BrTakenCount != 16'hFFFF)
                BrTakenCount <= BrTakenCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_issue.sv
// Scoreboard bench for instr_issue: expected fetch addresses and issue words queued by each test.
module tb_instr_issue;
    logic Clk = 1'b0;
    logic Clear_n = 1'b0;
    logic Start = 1'b0;
    logic Stop = 1'b0;
    logic Busy;
`ifdef INSTR_ISSUE_PERF_EN
    logic [15:0] issue_count;
    logic [15:0] br_taken_count;
`endif

    instr_issue_if #(.PC_W(8), .INSTR_W(8)) bus ();

    instr_issue #(.PC_W(8), .INSTR_W(8)) dut (
        .Clk(Clk),
        .Clear_n(Clear_n),
        .Start(Start),
        .Stop(Stop),
        .Busy(Busy),
        .bus(bus.master)
`ifdef INSTR_ISSUE_PERF_EN
        ,
        .IssueCount(issue_count),
        .BrTakenCount(br_taken_count)
`endif
    );

    always #5 Clk = ~Clk;

    logic [7:0] mem [256];
    logic [7:0] exp_addr [$];
    logic [7:0] exp_issue [$];
    logic       br_dec [$];
    logic       br_pending = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         n_acc = 0;
    int         n_taken = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Synchronous instruction memory, 1-cycle latency.
    always @(posedge Clk)
        if (bus.ImemRd) bus.ImemData <= mem[bus.ImemAddr];

    // Monitor: every read and every accept must match the next queued expectation.
    always @(negedge Clk) begin
        if (Clear_n) begin
            if (bus.ImemRd) begin
                if (exp_addr.size() == 0) check("unexpected_rd", {24'd0, bus.ImemAddr}, 32'hFFFF_FFFF);
                else check("imem_addr", {24'd0, bus.ImemAddr}, {24'd0, exp_addr.pop_front()});
            end
            if (bus.IssueValid && bus.IssueReady) begin
                if (exp_issue.size() == 0) begin
                    check("unexpected_issue", {24'd0, bus.Op, bus.Rs, bus.Rt, bus.Imm}, 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] w;
                    w = exp_issue.pop_front();
                    check("issue_word", {24'd0, bus.Op, bus.Rs, bus.Rt, bus.Imm}, {24'd0, w});
                    n_acc++;
                    if (w[7:6] == 2'b11) br_pending = 1'b1;
                end
            end
        end
    end

    // Branch responder: resolves a pending branch a few cycles later using the next queued decision.
    initial begin
        bus.BrValid = 1'b0;
        bus.BrTaken = 1'b0;
        forever begin
            @(negedge Clk);
            if (br_pending && br_dec.size() != 0) begin
                repeat (2) @(negedge Clk);
                bus.BrTaken = br_dec.pop_front();
                bus.BrValid = 1'b1;
                if (bus.BrTaken) n_taken++;
                @(negedge Clk);
                bus.BrValid = 1'b0;
                bus.BrTaken = 1'b0;
                br_pending  = 1'b0;
            end
        end
    end

    task automatic push(input logic [7:0] a);
        exp_addr.push_back(a);
        exp_issue.push_back(mem[a]);
    endtask

    task automatic finish_run(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_addr.size() != 0 && n < budget) begin @(negedge Clk); n++; end
        check({tag, "_drain"}, 32'(exp_addr.size()), 32'd0);
        Stop = 1'b1;
        n = 0;
        while ((Busy || exp_issue.size() != 0) && n < 40) begin @(negedge Clk); n++; end
        check({tag, "_idle"}, {31'd0, Busy}, 32'd0);
        repeat (4) begin
            @(negedge Clk);
            check({tag, "_no_rd"}, {31'd0, bus.ImemRd}, 32'd0);
        end
        Stop = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  {31'd0, Busy}, 32'd0);
        check({tag, "_rd"},    {31'd0, bus.ImemRd}, 32'd0);
        check({tag, "_addr"},  {24'd0, bus.ImemAddr}, 32'd0);
        check({tag, "_valid"}, {31'd0, bus.IssueValid}, 32'd0);
        check({tag, "_flds"},  {24'd0, bus.Op, bus.Rs, bus.Rt, bus.Imm}, 32'd0);
`ifdef INSTR_ISSUE_PERF_EN
        check({tag, "_icnt"},  {16'd0, issue_count}, 32'd0);
        check({tag, "_bcnt"},  {16'd0, br_taken_count}, 32'd0);
`endif
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 5) & 8'hBF;
        mem[0] = 8'h1B;
        mem[4] = 8'hC2;
        bus.IssueReady = 1'b1;
        #12;
        check_reset_outputs("reset");
        @(negedge Clk);
        Clear_n = 1'b1;

        // Run A: first-issue latency, stall, taken/not-taken branch at PC 4, Stop during FETCH.
        push(8'd0); push(8'd1); push(8'd2); push(8'd3); push(8'd4);
        push(8'd3); push(8'd4); push(8'd5);
        br_dec.push_back(1'b1); br_dec.push_back(1'b0);
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk); #1;
        check("lat_rd1", {31'd0, bus.ImemRd}, 32'd1);
        check("lat_busy1", {31'd0, Busy}, 32'd1);
        Start = 1'b0;
        @(posedge Clk); #1;
        check("lat_valid2", {31'd0, bus.IssueValid}, 32'd0);
        @(posedge Clk); #1;
        check("lat_valid3", {31'd0, bus.IssueValid}, 32'd1);
        check("lat_flds3", {24'd0, bus.Op, bus.Rs, bus.Rt, bus.Imm}, 32'h1B);
        @(posedge Clk); #1;
        bus.IssueReady = 1'b0;
        n = 0;
        while (!bus.IssueValid && n < 10) begin @(posedge Clk); #1; n++; end
        check("stall_wait", {31'd0, bus.IssueValid}, 32'd1);
        repeat (5) begin
            @(posedge Clk); #1;
            check("stall_valid", {31'd0, bus.IssueValid}, 32'd1);
            check("stall_flds", {24'd0, bus.Op, bus.Rs, bus.Rt, bus.Imm}, {24'd0, mem[1]});
            check("stall_no_rd", {31'd0, bus.ImemRd}, 32'd0);
        end
        bus.IssueReady = 1'b1;
        finish_run("runA", 200);
`ifdef INSTR_ISSUE_PERF_EN
        check("runA_icnt", {16'd0, issue_count}, 32'(n_acc));
        check("runA_bcnt", {16'd0, br_taken_count}, 32'd1);
`endif

        // BrValid outside BR_WAIT must be ignored.
        @(negedge Clk);
        bus.BrValid = 1'b1; bus.BrTaken = 1'b1;
        @(negedge Clk);
        bus.BrValid = 1'b0; bus.BrTaken = 1'b0;
        check("ign_br_busy", {31'd0, Busy}, 32'd0);
`ifdef INSTR_ISSUE_PERF_EN
        check("ign_br_bcnt", {16'd0, br_taken_count}, 32'd1);
`endif

        // Run B: restart at 0, branch not taken, sequential wrap 255->0, taken branch at 0 -> 255.
        mem[0] = 8'hC2;
        mem[4] = 8'h04;
        for (int a = 0; a < 256; a++) push(8'(a));
        push(8'd0); push(8'd255);
        br_dec.push_back(1'b0); br_dec.push_back(1'b1);
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        finish_run("runB", 2000);
`ifdef INSTR_ISSUE_PERF_EN
        check("runB_icnt", {16'd0, issue_count}, 32'(n_acc));
        check("runB_bcnt", {16'd0, br_taken_count}, 32'(n_taken));
`endif

        // Run C: asynchronous reset while waiting on a branch, then clean restart.
        push(8'd0);
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        n = 0;
        while ((exp_issue.size() != 0 || bus.IssueValid) && n < 20) begin @(negedge Clk); n++; end
        check("brw_reach", 32'(exp_issue.size()), 32'd0);
        check("brw_busy", {31'd0, Busy}, 32'd1);
        @(negedge Clk);
        #2 Clear_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        br_pending = 1'b0;
        n_acc = 0;
        n_taken = 0;
        @(negedge Clk);
        Clear_n = 1'b1;
        push(8'd0); push(8'd1);
        br_dec.push_back(1'b0);
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        finish_run("runC", 200);
`ifdef INSTR_ISSUE_PERF_EN
        check("runC_icnt", {16'd0, issue_count}, 32'd2);
        check("runC_bcnt", {16'd0, br_taken_count}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
